// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the data cache controller.
interface dcache_if;
  logic         rd_en;
  logic         wr_en;
  logic         is_byte;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         block_pipe_data_cache;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  rd_en, wr_en, is_byte, addr, wdata, mem_rdata, mem_ready,
    output rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_en, wr_en, is_byte, addr, wdata, mem_rdata, mem_ready,
    input  rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped 4 x 16-byte write-back, write-allocate data cache controller.
module dcache_ctrl (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e         state_q, state_d;
  logic [3:0]     valid_q, valid_d;
  logic [3:0]     dirty_q, dirty_d;
  logic [27:0]    miss_line_q, miss_line_d;
  logic [25:0]    tag_q [4];
  logic [127:0]   data_q [4];

  logic [1:0]     idx;
  logic [25:0]    tag;
  logic [1:0]     m_idx;
  logic           req;
  logic           hit;
  logic [127:0]   line;
  logic [127:0]   store_line;
  logic           store_en;
  logic           fill_en;

  assign idx   = bus.addr[5:4];
  assign tag   = bus.addr[31:6];
  assign m_idx = miss_line_q[1:0];
  assign req   = bus.rd_en | bus.wr_en;
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign line  = data_q[idx];

  // Load data reads the pre-store line, so a combined rd/wr returns old contents.
  always_comb begin
    if (bus.is_byte) begin
      bus.rdata = {24'b0, line[{bus.addr[3:0], 3'b000} +: 8]};
    end else begin
      bus.rdata = line[{bus.addr[3:2], 5'b00000} +: 32];
    end
  end

  always_comb begin
    store_line = line;
    if (bus.is_byte) begin
      store_line[{bus.addr[3:0], 3'b000} +: 8] = bus.wdata[7:0];
    end else begin
      store_line[{bus.addr[3:2], 5'b00000} +: 32] = bus.wdata;
    end
  end

  always_comb begin
    state_d                   = state_q;
    valid_d                   = valid_q;
    dirty_d                   = dirty_q;
    miss_line_d               = miss_line_q;
    store_en                  = 1'b0;
    fill_en                   = 1'b0;
    bus.block_pipe_data_cache = 1'b0;
    bus.mem_req               = 1'b0;
    bus.mem_we                = 1'b0;
    bus.mem_addr              = 32'h0;
    bus.mem_wdata             = 128'h0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            if (bus.wr_en) begin
              store_en     = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            bus.block_pipe_data_cache = 1'b1;
            miss_line_d               = bus.addr[31:4];
            state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StFill;
          end
        end
      end
      StWriteback: begin
        bus.block_pipe_data_cache = 1'b1;
        bus.mem_req               = 1'b1;
        bus.mem_we                = 1'b1;
        bus.mem_addr              = {tag_q[m_idx], m_idx, 4'b0000};
        bus.mem_wdata             = data_q[m_idx];
        if (bus.mem_ready) begin
          dirty_d[m_idx] = 1'b0;
          state_d        = StFill;
        end
      end
      StFill: begin
        bus.block_pipe_data_cache = 1'b1;
        bus.mem_req               = 1'b1;
        bus.mem_addr              = {miss_line_q, 4'b0000};
        if (bus.mem_ready) begin
          fill_en        = 1'b1;
          valid_d[m_idx] = 1'b1;
          dirty_d[m_idx] = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= 4'b0;
      dirty_q     <= 4'b0;
      miss_line_q <= 28'h0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Line storage survives reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (store_en) begin
      data_q[idx] <= store_line;
    end else if (fill_en) begin
      data_q[m_idx] <= bus.mem_rdata;
      tag_q[m_idx]  <= miss_line_q[27:2];
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a behavioural line memory and byte reference model.
module tb_dcache_ctrl;
  parameter int unsigned MEM_LAT_MIN = 1;

  logic clk;
  logic reset;
  dcache_if dif ();

  dcache_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wd;
  } mtx_t;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  logic mem_chk_en = 1'b1;
  logic [31:0]  exp_q  [$];
  mtx_t         mexp_q [$];
  logic [127:0] mem_lines [logic [31:0]];
  logic [7:0]   ref_mem   [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h44) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [127:0] get_line(input logic [31:0] la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a);
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic bt);
    logic [31:0] b;
    if (bt) return {24'b0, ref_byte(a)};
    b = {a[31:2], 2'b00};
    return {ref_byte(b + 3), ref_byte(b + 2), ref_byte(b + 1), ref_byte(b)};
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic bt, input logic [31:0] d);
    logic [31:0] b;
    if (bt) begin
      ref_mem[a] = d[7:0];
    end else begin
      b = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) ref_mem[b + 32'(i)] = d[i*8 +: 8];
    end
  endfunction

  function automatic void push_mtx(input logic we, input logic [31:0] a, input logic [127:0] wd);
    mtx_t t;
    t.we = we;
    t.addr = a;
    t.wd = wd;
    mexp_q.push_back(t);
  endfunction

  // Memory responder: mem_ready pulses in the lat-th cycle of each mem_req.
  initial begin
    int cnt;
    cnt = 0;
    dif.mem_ready = 1'b0;
    dif.mem_rdata = 128'h0;
    forever begin
      @(posedge clk);
      #1;
      dif.mem_ready = 1'b0;
      if (dif.mem_req && !reset) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          dif.mem_ready = 1'b1;
          if (dif.mem_we) mem_lines[dif.mem_addr] = dif.mem_wdata;
          else dif.mem_rdata = get_line(dif.mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected load data and memory transactions as the DUT presents them.
  initial begin
    logic prev_req, prev_rdy, stable, start;
    mtx_t         cur, e;
    logic [31:0]  ed;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    stable   = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (dif.rd_en && !dif.block_pipe_data_cache) begin
          if (exp_q.size() == 0) begin
            check("rdata_unexpected_load", 1'b1, 1'b0);
          end else begin
            ed = exp_q.pop_front();
            check("rdata", dif.rdata, ed);
          end
        end
        if (dif.mem_req && !dif.block_pipe_data_cache) check("mem_req_without_block", 1'b1, 1'b0);
        start = dif.mem_req && (!prev_req || prev_rdy);
        if (start) begin
          cur.we = dif.mem_we;
          cur.addr = dif.mem_addr;
          cur.wd = dif.mem_wdata;
          stable = (dif.mem_addr[3:0] == 4'h0);
          if (mem_chk_en) begin
            if (mexp_q.size() == 0) begin
              check("mem_txn_unexpected", 1'b1, 1'b0);
            end else begin
              e = mexp_q.pop_front();
              check("mem_we", dif.mem_we, e.we);
              check("mem_addr", dif.mem_addr, e.addr);
              if (e.we) check("mem_wdata", dif.mem_wdata, e.wd);
            end
          end
        end else if (dif.mem_req) begin
          if (dif.mem_we !== cur.we || dif.mem_addr !== cur.addr || dif.mem_wdata !== cur.wd)
            stable = 1'b0;
        end
        if (dif.mem_req && dif.mem_ready) check("mem_stable_aligned", stable, 1'b1);
        prev_req = dif.mem_req;
        prev_rdy = dif.mem_req && dif.mem_ready;
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic bt, input logic [31:0] a,
                        input logic [31:0] d, input logic use_exp, input logic [31:0] exp,
                        output int stall);
    logic done;
    @(posedge clk);
    #1;
    if (rd) exp_q.push_back(use_exp ? exp : ref_load(a, bt));
    if (wr) ref_store(a, bt, d);
    dif.rd_en   = rd;
    dif.wr_en   = wr;
    dif.is_byte = bt;
    dif.addr    = a;
    dif.wdata   = d;
    stall = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!dif.block_pipe_data_cache) begin
        done = 1'b1;
      end else begin
        stall++;
        if (stall > 200) begin
          check("access_timeout", 1'b1, 1'b0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    dif.rd_en = 1'b0;
    dif.wr_en = 1'b0;
  endtask

  initial begin
    int st, n, op;
    logic [31:0] a, d;
    logic bt;
    reset = 1'b1;
    dif.rd_en = 1'b0;
    dif.wr_en = 1'b0;
    dif.is_byte = 1'b0;
    dif.addr = 32'h0;
    dif.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_req", dif.mem_req, 1'b0);
    check("reset_mem_we", dif.mem_we, 1'b0);
    check("reset_mem_addr", dif.mem_addr, 32'h0);
    check("reset_block_idle", dif.block_pipe_data_cache, 1'b0);
    reset = 1'b0;

    // Cold word load with a three-cycle fill.
    lat = 3;
    push_mtx(1'b0, 32'h40, 128'h0);
    access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 32'hDEADBEEF, st);
    check("clean_miss_stall", st, 4);

    // Byte store hit, then word and byte loads of the merged data.
    access(1'b0, 1'b1, 1'b1, 32'h45, 32'hA5, 1'b0, 32'h0, st);
    check("store_hit_stall", st, 0);
    access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 32'hDEADA5EF, st);
    check("load_hit_stall", st, 0);
    access(1'b1, 1'b0, 1'b1, 32'h45, 32'h0, 1'b1, 32'h000000A5, st);

    // Combined rd/wr returns the old word; a later load sees the new one.
    access(1'b1, 1'b1, 1'b0, 32'h48, 32'h12345678, 1'b1, init_word(32'h48), st);
    access(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 1'b1, 32'h12345678, st);

    // Dirty eviction of line 0x40 by a load of 0x80.
    lat = 2;
    push_mtx(1'b1, 32'h40, {init_word(32'h4C), 32'h12345678, 32'hDEADA5EF, init_word(32'h40)});
    push_mtx(1'b0, 32'h80, 128'h0);
    access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, init_word(32'h80), st);
    check("dirty_miss_stall", st, 5);
    access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, init_word(32'h80), st);
    check("refill_hit_stall", st, 0);

    // Reset in the middle of a fill; the held load must miss again.
    lat = 5;
    push_mtx(1'b0, 32'hC0, 128'h0);
    push_mtx(1'b0, 32'hC0, 128'h0);
    @(posedge clk);
    #1;
    exp_q.push_back(init_word(32'hC0));
    dif.rd_en = 1'b1;
    dif.is_byte = 1'b0;
    dif.addr = 32'hC0;
    n = 0;
    while (!dif.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fill_started", dif.mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_drops_mem_req", dif.mem_req, 1'b0);
    check("reset_mem_addr_mid", dif.mem_addr, 32'h0);
    check("reset_block_pending", dif.block_pipe_data_cache, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat = 2;
    n = 0;
    @(negedge clk);
    while (dif.block_pipe_data_cache && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("refetch_after_reset", dif.block_pipe_data_cache, 1'b0);
    @(posedge clk);
    #1;
    dif.rd_en = 1'b0;
    check("directed_mem_txns_done", mexp_q.size(), 0);

    // Random stream against the byte reference model.
    mem_chk_en = 1'b0;
    for (int i = 0; i < 250; i++) begin
      lat = MEM_LAT_MIN + $urandom_range(0, 2);
      op  = $urandom_range(0, 7);
      a   = {23'b0, 9'($urandom_range(0, 511))};
      d   = $urandom;
      bt  = 1'($urandom_range(0, 1));
      if (op < 4) access(1'b1, 1'b0, bt, a, d, 1'b0, 32'h0, st);
      else if (op < 7) access(1'b0, 1'b1, bt, a, d, 1'b0, 32'h0, st);
      else access(1'b1, 1'b1, bt, a, d, 1'b0, 32'h0, st);
    end
    repeat (3) @(posedge clk);
    check("loads_all_returned", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
